alu_issue_ctrl: RTL and testbench

//  Upstream command stage for the 32-bit ALU: buffers (a, b, opcode) commands in a small FIFO.

---
 rtl/alu_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Command FIFO, operand issue and result capture stage in front of the 32-bit ALU.
// Optional feature macro: ALU_DIV0_FLAG_EN (drives rsp_div0 at capture; otherwise tied 0).
module alu_issue_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_opcode,
  input  logic [63:0] alu_res,
  input  logic        alu_ov,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_res,
  output logic        rsp_ov,
  output logic        rsp_div0,
  output logic        busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [OCC_W-1:0]   occ, occ_d;
  logic [PTR_W-1:0]   wptr, rptr;
  cmd_t               fifo_mem [FIFO_DEPTH];
  cmd_t               head;
  logic               push, pop, capture, rsp_clr;

  // Full/empty come from the occupancy count; ready is masked during reset
  assign cmd_ready = !rst && (occ != OCC_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rptr];
  assign busy      = (occ != '0) || (state != IDLE);

  // Next-state and control strobes
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    capture = 1'b0;
    rsp_clr = 1'b0;
    case (state)
      IDLE: begin
        if (occ != '0) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ;
    case ({push, pop})
      2'b10:   occ_d = occ + OCC_W'(1);
      2'b01:   occ_d = occ - OCC_W'(1);
      default: occ_d = occ;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by occ
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr] <= cmd_t'({cmd_a, cmd_b, cmd_op});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      occ        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_res    <= '0;
      rsp_ov     <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      occ   <= occ_d;
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      // Operands change only on a pop and are held through EXEC and RESP
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_opcode <= head.op;
        rptr       <= rptr + PTR_W'(1);
      end
      if (capture) begin
        rsp_res   <= alu_res;
        rsp_ov    <= alu_ov;
        rsp_valid <= 1'b1;
      end else if (rsp_clr) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_DIV0_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_div0 <= 1'b0;
    end else if (capture) begin
      rsp_div0 <= (alu_opcode == 3'b011) && (alu_b == '0);
    end
  end
`else
  assign rsp_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU model.
// Honours ALU_DIV0_FLAG_EN for the rsp_div0 expectation.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_opcode;
  logic [63:0] alu_res;
  logic        alu_ov;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_res;
  logic        rsp_ov;
  logic        rsp_div0;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_res    (alu_res),
    .alu_ov     (alu_ov),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_res    (rsp_res),
    .rsp_ov     (rsp_ov),
    .rsp_div0   (rsp_div0),
    .busy       (busy)
  );

  // Combinational ALU: add, sub, mul, div (x/0 = 0), xor otherwise
  logic [31:0] sum32;
  assign sum32 = alu_a + alu_b;
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_res = {32'h0, alu_a} + {32'h0, alu_b};
        alu_ov  = (alu_a[31] == alu_b[31]) && (sum32[31] != alu_a[31]);
      end
      3'b001:  alu_res = {32'h0, alu_a - alu_b};
      3'b010:  alu_res = {32'h0, alu_a} * {32'h0, alu_b};
      3'b011:  alu_res = (alu_b == '0) ? 64'h0 : {32'h0, alu_a / alu_b};
      default: alu_res = {32'h0, alu_a ^ alu_b};
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(rsp_valid), 64'd1);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    while (!cmd_ready && n < 40) begin
      tick();
      n++;
    end
    chk("push_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    bit          stale;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_rsp_res", rsp_res, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // 1: 5+7 with exact latency
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 32'd5; cmd_b = 32'd7; cmd_op = 3'b000;
    tick();                       // accept edge E
    cmd_valid = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    tick();                       // E+1 pop
    chk("t1_alu_a", 64'(alu_a), 64'd5);
    chk("t1_alu_b", 64'(alu_b), 64'd7);
    chk("t1_valid_e1", 64'(rsp_valid), 64'd0);
    tick();                       // E+2
    chk("t1_valid_e2", 64'(rsp_valid), 64'd0);
    tick();                       // E+3 capture
    chk("t1_valid_e3", 64'(rsp_valid), 64'd1);
    chk("t1_res", rsp_res, 64'd12);
    chk("t1_ov", 64'(rsp_ov), 64'd0);
    tick();
    chk("t1_valid_e4", 64'(rsp_valid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Signed overflow captured as-is
    push(32'h7FFF_FFFF, 32'h1, 3'b000);
    wait_rsp("t1b");
    chk("t1b_res", rsp_res, 64'h8000_0000);
    chk("t1b_ov", 64'(rsp_ov), 64'd1);
    tick();

    // 2: five back-to-back commands with response stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 32'(100 + i); cmd_b = 32'(3 * i); cmd_op = 3'b000;
      chk("t2_ready_fill", 64'(cmd_ready), 64'd1);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t2_full", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      wait_rsp("t2");
      chk("t2_res", rsp_res, 64'(100 + 4 * i));
      held = rsp_res;
      tick(); tick();
      chk("t2_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t2_hold_res", rsp_res, held);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t2_release", 64'(rsp_valid), 64'd0);
    end

    // 3: divide by zero
    rsp_ready = 1'b1;
    push(32'd17, 32'd0, 3'b011);
    wait_rsp("t3");
    chk("t3_res", rsp_res, 64'd0);
`ifdef ALU_DIV0_FLAG_EN
    chk("t3_div0", 64'(rsp_div0), 64'd1);
`else
    chk("t3_div0", 64'(rsp_div0), 64'd0);
`endif
    tick();

    // 4: multiply, operands held through EXEC
    push(32'hFFFF_FFFF, 32'd2, 3'b010);
    tick();
    chk("t4_alu_a0", 64'(alu_a), 64'hFFFF_FFFF);
    chk("t4_alu_b0", 64'(alu_b), 64'd2);
    chk("t4_op0", 64'(alu_opcode), 64'd2);
    tick();
    chk("t4_alu_a1", 64'(alu_a), 64'hFFFF_FFFF);
    chk("t4_alu_b1", 64'(alu_b), 64'd2);
    tick();
    chk("t4_valid", 64'(rsp_valid), 64'd1);
    chk("t4_res", rsp_res, 64'h1_FFFF_FFFE);
    chk("t4_div0", 64'(rsp_div0), 64'd0);
    tick();

    // 5: reset during EXEC with two queued
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = 32'(50 + i); cmd_b = 32'd1; cmd_op = 3'b000;
      tick();
    end
    cmd_valid = 1'b0;
    chk("t5_in_exec", 64'(rsp_valid), 64'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", 64'(cmd_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_valid", 64'(rsp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ready", 64'(cmd_ready), 64'd1);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) stale = 1'b1;
    end
    chk("t5_no_stale", 64'(stale), 64'd0);

    // 6: push with pop at occupancy 3, then ten commands in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_a = 32'(1000 + i); cmd_b = 32'(i); cmd_op = 3'b000;
      tick();
    end
    cmd_valid = 1'b0;
    wait_rsp("t6_c0");
    chk("t6_res0", rsp_res, 64'd1000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 32'd1004; cmd_b = 32'd4;
    tick();                       // pop c1 and push c4 together
    chk("t6_occ3_ready", 64'(cmd_ready), 64'd1);
    cmd_a = 32'd1005; cmd_b = 32'd5;
    tick();
    chk("t6_occ4_full", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      wait_rsp("t6_drain");
      chk("t6_res", rsp_res, 64'(1000 + 2 * i));
      tick();
    end
    for (int i = 6; i < 10; i++) begin
      push(32'(1000 + i), 32'(i), 3'b000);
      wait_rsp("t6_tail");
      chk("t6_tail_res", rsp_res, 64'(1000 + 2 * i));
      tick();
    end
    chk("t6_end_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
